// File: rtl/dependence_pair.sv
// Majority vote and parity-pattern (1,0,1) detector over three synchronized async inputs,
// with a saturating count of detected patterns.
module dependence_pair #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    output logic             Result,
    output logic             Q,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SAW1  = 2'd1,
        SAW10 = 2'd2
    } state_t;

    // One chain per input, packed side by side as {a, b, c}.
    logic [2:0]       sync_q [SYNC_STAGES];
    logic [2:0]       abc_s;
    logic             par;
    state_t           state_q, state_d;
    logic             result_q, result_d;
    logic             q_q, q_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 3'b000;
            end
        end else begin
            sync_q[0] <= {a, b, c};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign abc_s = sync_q[SYNC_STAGES-1];
    assign par   = abc_s[2] ^ abc_s[1] ^ abc_s[0];

    always_comb begin
        state_d  = state_q;
        result_d = (abc_s[2] & abc_s[1]) | (abc_s[2] & abc_s[0]) | (abc_s[1] & abc_s[0]);
        q_d      = (state_q == SAW10) & par;
        unique case (state_q)
            IDLE:    state_d = par ? SAW1 : IDLE;
            SAW1:    state_d = par ? SAW1 : SAW10;
            SAW10:   state_d = par ? SAW1 : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The counter is enabled by the registered pulse, so it lags Q by one edge.
    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if (q_q && (hit_cnt_q != {CNT_W{1'b1}})) begin
            hit_cnt_d = hit_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            result_q  <= 1'b0;
            q_q       <= 1'b0;
            hit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            q_q       <= q_d;
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign Result      = result_q;
    assign Q           = q_q;
    assign hit_cnt     = hit_cnt_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dependence_pair.sv
// Directed bench for dependence_pair: default instance plus a CNT_W=2 instance on shared inputs.
module tb_dependence_pair;

    logic       clk;
    logic       rst_n;
    logic       a, b, c;
    logic       result, q;
    logic [7:0] cnt;
    logic [1:0] st;
    logic       result_s, q_s;
    logic [1:0] cnt_s;
    logic [1:0] st_s;

    int total = 0;
    int bad   = 0;

    dependence_pair dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c),
        .Result(result), .Q(q), .hit_cnt(cnt), .dbg_state_o(st)
    );

    dependence_pair #(.SYNC_STAGES(2), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c),
        .Result(result_s), .Q(q_s), .hit_cnt(cnt_s), .dbg_state_o(st_s)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] abc;
        logic       exp_result;
    } maj_vec_t;

    maj_vec_t maj_tbl[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        {a, b, c} = 3'b000;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // parity bit 1 -> abc=100, 0 -> abc=000
    task automatic drive_par(input int p);
        {a, b, c} = (p != 0) ? 3'b100 : 3'b000;
    endtask

    int         pat_par[10]  = '{1, 0, 1, 0, 1, 0, 0, 0, 0, 0};
    int         pat_q[10]    = '{0, 0, 0, 0, 1, 0, 1, 0, 0, 0};
    int         nm_par[10]   = '{1, 1, 0, 0, 1, 0, 0, 0, 0, 0};
    int         sat_par[14]  = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0};
    int         sat_q[14]    = '{0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    int         sat_cs[14]   = '{0, 0, 0, 0, 0, 1, 1, 2, 2, 3, 3, 3, 3, 3};
    int         sat_cm[14]   = '{0, 0, 0, 0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5};
    logic       prev_q;
    logic       prev_res;

    initial begin
        maj_tbl[0] = '{3'b110, 1'b1};
        maj_tbl[1] = '{3'b100, 1'b0};
        maj_tbl[2] = '{3'b011, 1'b1};
        maj_tbl[3] = '{3'b111, 1'b1};
        maj_tbl[4] = '{3'b000, 1'b0};
        maj_tbl[5] = '{3'b101, 1'b1};
        maj_tbl[6] = '{3'b001, 1'b0};

        // reset held with all inputs high
        rst_n = 1'b0;
        {a, b, c} = 3'b111;
        for (int i = 0; i < 5; i++) begin
            step();
            check("rst_result", result, 0);
            check("rst_q", q, 0);
            check("rst_cnt", cnt, 0);
            check("rst_cnt_sat", cnt_s, 0);
        end
        {a, b, c} = 3'b000;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // majority: old value after 2 edges, new value after the 3rd
        prev_res = 1'b0;
        for (int i = 0; i < 7; i++) begin
            {a, b, c} = maj_tbl[i].abc;
            step();
            step();
            check("maj_latency_old", result, prev_res);
            step();
            check("maj_result", result, maj_tbl[i].exp_result);
            step();
            prev_res = maj_tbl[i].exp_result;
        end

        // pattern 1,0,1,0,1 -> two pulses
        do_reset();
        prev_q = 1'b0;
        for (int k = 0; k < 10; k++) begin
            drive_par(pat_par[k]);
            step();
            check("pat_q", q, pat_q[k]);
            check("pat_q_not_back_to_back", prev_q & q, 0);
            prev_q = q;
        end
        check("pat_cnt", cnt, 2);
        check("pat_cnt_sat", cnt_s, 2);

        // non-match 1,1,0,0,1
        for (int k = 0; k < 10; k++) begin
            drive_par(nm_par[k]);
            step();
            check("nomatch_q", q, 0);
        end
        check("nomatch_cnt", cnt, 2);

        // five overlapping matches, narrow counter saturates at 3
        do_reset();
        prev_q = 1'b0;
        for (int k = 0; k < 14; k++) begin
            drive_par(sat_par[k]);
            step();
            check("sat_q", q_s, sat_q[k]);
            check("sat_cnt_narrow", cnt_s, sat_cs[k]);
            check("sat_cnt_wide", cnt, sat_cm[k]);
            check("sat_q_not_back_to_back", prev_q & q_s, 0);
            prev_q = q_s;
        end

        // async reset after bits 1,0 with a third 1 already in the synchronizer
        {a, b, c} = 3'b111; step();
        {a, b, c} = 3'b110; step();
        {a, b, c} = 3'b111; step();
        step();
        check("pre_rst_result", result, 1);
        check("pre_rst_state", st, 2);
        check("pre_rst_cnt", cnt, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_result", result, 0);
        check("async_rst_q", q, 0);
        check("async_rst_cnt", cnt, 0);
        check("async_rst_cnt_sat", cnt_s, 0);
        check("async_rst_state", st, 0);
        #1;
        rst_n = 1'b1;
        step();
        {a, b, c} = 3'b000;
        for (int k = 0; k < 8; k++) begin
            step();
            check("post_rst_q", q, 0);
        end
        check("post_rst_cnt", cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
